// File: rtl/adc_pattern_generator_if.sv
// Sample stream from the pattern generator to its sink.
// Handshake: a sample transfers in any cycle where data_valid && data_ready;
// data is stable while data_valid is high and unaccepted.
`timescale 1ns/1ps
interface adc_pattern_generator_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/adc_pattern_generator.sv
// Multi-channel synthetic ADC source: ramp, constant, LFSR and min/max toggle
// patterns at a programmable sample rate, with burst length and drop counting.
`timescale 1ns/1ps
module adc_pattern_generator #(
    parameter int CHANNEL_NUM    = 4,
    parameter int ADC_BIT_NUM    = 10,
    parameter int OUTPUT_BIT_NUM = 16,
    parameter int DIV_WIDTH      = 8,
    parameter int SIGN_EXT       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [15:0]            burst_len,
    input  logic [ADC_BIT_NUM-1:0] const_value,
    adc_pattern_generator_if.master dout,
    output logic                   busy,
    output logic [15:0]            drop_cnt
);
    localparam int DATA_W = OUTPUT_BIT_NUM * CHANNEL_NUM;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [1:0]             mode_q, mode_d;
    logic [15:0]            burst_q, burst_d;
    logic [15:0]            sent_q, sent_d;
    logic [ADC_BIT_NUM-1:0] ramp_q, ramp_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   tog_q, tog_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic [15:0]            drop_q, drop_d;

    logic                      tick;
    logic                      present;
    logic                      accept;
    logic [ADC_BIT_NUM-1:0]    raw;
    logic [OUTPUT_BIT_NUM-1:0] lane;
    logic [DATA_W-1:0]         sample;

    // Current generator state rendered into lanes; only latched on a presented tick.
    always_comb begin
        raw    = '0;
        lane   = '0;
        sample = '0;
        for (int ii = 0; ii < CHANNEL_NUM; ii++) begin
            case (mode_q)
                2'd0:    raw = ramp_q + ADC_BIT_NUM'(ii);
                2'd1:    raw = const_value;
                2'd2:    raw = lfsr_q[ADC_BIT_NUM-1:0] ^ ADC_BIT_NUM'(ii * 32'h1111);
                default: raw = {ADC_BIT_NUM{tog_q}};
            endcase
            lane = {OUTPUT_BIT_NUM{(SIGN_EXT != 0) && raw[ADC_BIT_NUM-1]}};
            lane[ADC_BIT_NUM-1:0] = raw;
            sample[ii*OUTPUT_BIT_NUM +: OUTPUT_BIT_NUM] = lane;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        sent_d  = sent_q;
        ramp_d  = ramp_q;
        lfsr_d  = lfsr_q;
        tog_d   = tog_q;
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        tick    = 1'b0;
        present = 1'b0;
        accept  = valid_q && dout.data_ready;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    div_d   = div;
                    burst_d = burst_len;
                    sent_d  = '0;
                    ramp_d  = '0;
                    lfsr_d  = LFSR_SEED;
                    tog_d   = 1'b0;
                    drop_d  = '0;
                end
            end
            default: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q == div_q) begin
                        tick  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                    if (tick) begin
                        // Generator advances on every tick, even when the sample is dropped.
                        ramp_d = ramp_q + ADC_BIT_NUM'(1);
                        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                        tog_d  = ~tog_q;
                        if (valid_q && !dout.data_ready) begin
                            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                        end else begin
                            present = 1'b1;
                            sent_d  = sent_q + 16'd1;
                            if (burst_q != 16'd0 && sent_q + 16'd1 == burst_q) begin
                                state_d = S_IDLE;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
            end
        endcase

        if (present) begin
            data_d  = sample;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            mode_q  <= '0;
            burst_q <= '0;
            sent_q  <= '0;
            ramp_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            tog_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            sent_q  <= sent_d;
            ramp_q  <= ramp_d;
            lfsr_q  <= lfsr_d;
            tog_q   <= tog_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign dout.data       = data_q;
    assign dout.data_valid = valid_q;
    assign busy            = (state_q == S_RUN);
    assign drop_cnt        = drop_q;
endmodule

// File: doc/adc_pattern_generator.md
ADC_PATTERN_GENERATOR -- requirements
Module: adc_pattern_generator

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 4: number of channels, 1..16.
REQ-002 The block SHALL have parameter ADC_BIT_NUM, default 10: raw sample width, 2..16.
REQ-003 The block SHALL have parameter OUTPUT_BIT_NUM, default 16: per-channel output lane width, >= ADC_BIT_NUM.
REQ-004 The block SHALL have parameter DIV_WIDTH, default 8: width of the rate divider.
REQ-005 The block SHALL have parameter SIGN_EXT, default 0: 0 zero-extends raw samples into the lane, 1 replicates the raw MSB.
REQ-006 The port list SHALL be as follows; one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a run.
- stop  in  1  single-cycle pulse; aborts a run.
- mode  in  2  pattern: 0 ramp, 1 constant, 2 LFSR, 3 min/max toggle.
- div  in  DIV_WIDTH  sample period minus 1, in clocks.
- burst_len  in  16  samples per run; 0 means continuous.
- const_value  in  ADC_BIT_NUM  value for mode 1.
- data  out  OUTPUT_BIT_NUM*CHANNEL_NUM  channel ii in lane [ii*OUTPUT_BIT_NUM +: OUTPUT_BIT_NUM].
- data_valid  out  1  data holds an unaccepted sample.
- data_ready  in  1  sink accepts when data_valid && data_ready.
- busy  out  1  high while in RUN.
- drop_cnt  out  16  saturating count of samples discarded by backpressure.

Function
REQ-007 The FSM SHALL have two states, IDLE and RUN: start in IDLE -> RUN; stop in RUN -> IDLE; burst completion -> IDLE; start in RUN is ignored; stop has priority over start.
REQ-008 The tick counter SHALL count 0..div while in RUN and assert a tick in the cycle cnt==div, then return to 0; div=0 -> tick every cycle; the counter SHALL be held at 0 in IDLE.
REQ-009 The first tick after entering RUN SHALL occur div+1 cycles after the start cycle.
REQ-010 The mode and div inputs SHALL be sampled on the start cycle and held constant for the whole run.
REQ-011 On each tick the generator SHALL advance one step and present a new sample; data and data_valid SHALL update in the cycle after the tick (latency 1).
REQ-012 Ramp (mode 0): channel ii SHALL start at ii mod 2^ADC_BIT_NUM and increment by 1 per step, wrapping 2^ADC_BIT_NUM-1 -> 0.
REQ-013 Constant (mode 1): every channel SHALL output const_value, sampled at each tick.
REQ-014 LFSR (mode 2): a single 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at start) SHALL shift once per step; channel ii SHALL output the low ADC_BIT_NUM bits of (lfsr XOR ii*16'h1111).
REQ-015 Toggle (mode 3): all channels SHALL output the all-zeros value on the first sample, then all-ones, alternating.
REQ-016 The raw sample SHALL occupy the lane LSBs; the upper bits SHALL be zero (SIGN_EXT=0) or copies of the raw MSB (SIGN_EXT=1).
REQ-017 Backpressure: if a tick occurs while data_valid=1 and data_ready=0, the new sample SHALL be discarded, the output SHALL be held, drop_cnt SHALL increment (saturating at 16'hFFFF), and the generator state SHALL still advance.
REQ-018 If a tick coincides with acceptance (data_valid && data_ready), the new sample SHALL replace the old one and data_valid SHALL stay 1.
REQ-019 Burst accounting SHALL count presented samples only; when the burst_len-th sample is presented, the FSM SHALL go to IDLE in the same cycle; a pending data_valid SHALL remain until it is accepted.
REQ-020 A stop SHALL clear the tick counter and discard generator state; a sample already presented SHALL remain valid until it is accepted.
REQ-021 drop_cnt SHALL clear on start.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE.

Reset
REQ-023 On assertion of rst, asynchronously: FSM = IDLE, counters = 0, LFSR = 0xACE1, data = 0, data_valid = 0, busy = 0, drop_cnt = 0.
REQ-024 Reset asserted mid-run SHALL abort the run with no further output; after release the block SHALL remain IDLE until start.

Verification
REQ-025 Ramp run, CHANNEL_NUM=4, ADC_BIT_NUM=10, div=3, burst_len=0, ready=1 -> first valid 5 cycles after start, then one sample every 4 cycles; channel 3 reads 3,4,5,...; wraps 1023 -> 0.
REQ-026 SIGN_EXT=1, mode 3 -> lanes read 16'h0000 then 16'hFFFF alternately; with SIGN_EXT=0 the lanes read 16'h0000 then 16'h03FF.
REQ-027 div=0, burst_len=5, ready=1 -> exactly 5 valid samples on consecutive cycles, then busy=0.
REQ-028 ready=0 for 10 ticks after the first sample -> data holds the first sample, drop_cnt=10; on release, the next tick shows a ramp value advanced by 11.
REQ-029 LFSR mode: stream matches the golden model sequence starting 0xACE1; channel 1 = channel 0 XOR 0x111 (10-bit).
REQ-030 rst pulse mid-run, then stop and start pulsed in the same cycle -> outputs zero immediately and the block stays IDLE.
